// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter
// Purpose  : Round-robin arbiter in front of one shared iterative restoring
//            divider (one quotient bit per cycle). The result returns with
//            the owning requester's index over a valid/ready handshake.
// Ports    : clk, rst_n            - clock, async active-low reset
//            req_valid/req_ready   - per-requester request strobe / grant
//            req_a/req_b           - packed dividends/divisors, SIZE each
//            resp_valid/resp_ready - result handshake
//            resp_id/q/r/dbz       - owner, quotient, remainder, div-by-zero
// Revision : 1.0 - initial release
// ============================================================================
module divider_arbiter #(
  parameter int SIZE = 8,
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*SIZE-1:0] req_a,
  input  logic [NREQ*SIZE-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [SIZE-1:0]      resp_q,
  output logic [SIZE-1:0]      resp_r,
  output logic                 resp_dbz
);

  localparam int              CW         = $clog2(SIZE + 1);
  localparam logic [CW-1:0]   C_CNT_INIT = CW'(SIZE);
  localparam logic [CW-1:0]   C_CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [SIZE-1:0] r_q;
  logic [SIZE:0]   r_p;
  logic [CW-1:0]   r_cnt;

  logic            r_resp_valid;
  logic [IDW-1:0]  r_resp_id;
  logic [SIZE-1:0] r_resp_q;
  logic [SIZE-1:0] r_resp_r;
  logic            r_resp_dbz;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [NREQ-1:0] w_grant;
  logic [SIZE-1:0] w_win_a;
  logic [SIZE-1:0] w_win_b;
  logic            w_accept;
  logic [IDW-1:0]  w_ptr_nxt;

  logic [SIZE:0]   w_p_shift;
  logic            w_p_ge;
  logic [SIZE:0]   w_p_sub;
  logic [SIZE-1:0] w_q_shift;
  logic            w_calc_last;

  // Round-robin search: outer loop walks priority order starting at r_ptr,
  // inner loop picks the matching requester so every index is a loop constant.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_grant = '0;
    w_win_a = '0;
    w_win_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req_valid[i] && (i == ((int'(r_ptr) + k) % NREQ))) begin
          w_found    = 1'b1;
          w_win      = IDW'(i);
          w_grant[i] = 1'b1;
          w_win_a    = req_a[i*SIZE +: SIZE];
          w_win_b    = req_b[i*SIZE +: SIZE];
        end
      end
    end
  end

  // Grant is masked while reset is held so no requester sees a false accept.
  assign w_accept  = (r_state == S_IDLE) && w_found && rst_n;
  assign req_ready = w_accept ? w_grant : '0;
  assign w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + IDW'(1);

  // One restoring-division step. The partial remainder is shifted as a whole
  // so its top bit simply drops out; after a subtract it always fits SIZE bits.
  assign w_p_shift   = (r_p << 1) | (SIZE+1)'(r_a[SIZE-1]);
  assign w_p_ge      = (w_p_shift >= {1'b0, r_b});
  assign w_p_sub     = w_p_ge ? (w_p_shift - {1'b0, r_b}) : w_p_shift;
  assign w_q_shift   = (r_q << 1) | SIZE'(w_p_ge);
  assign w_calc_last = (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_win_b == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_calc_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_q          <= '0;
      r_p          <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_q     <= '0;
      r_resp_r     <= '0;
      r_resp_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ptr <= w_ptr_nxt;
            r_id  <= w_win;
            r_a   <= w_win_a;
            r_b   <= w_win_b;
            r_q   <= '0;
            r_p   <= '0;
            r_cnt <= C_CNT_INIT;
            // Zero divisor skips the iteration and presents the result now.
            if (w_win_b == '0) begin
              r_resp_valid <= 1'b1;
              r_resp_id    <= w_win;
              r_resp_q     <= '1;
              r_resp_r     <= w_win_a;
              r_resp_dbz   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_p   <= w_p_sub;
          r_a   <= r_a << 1;
          r_q   <= w_q_shift;
          r_cnt <= r_cnt - CW'(1);
          if (w_calc_last) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_id;
            r_resp_q     <= w_q_shift;
            r_resp_r     <= w_p_sub[SIZE-1:0];
            r_resp_dbz   <= 1'b0;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_q     = r_resp_q;
  assign resp_r     = r_resp_r;
  assign resp_dbz   = r_resp_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_arbiter
// Purpose  : Self-checking bench for divider_arbiter. A transaction-level
//            model (countdown latency, '/' and '%' results, round-robin
//            pointer) predicts every output each cycle; directed literal
//            checks pin the model, then randomized traffic follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_arbiter;

  localparam int SIZE = 8;
  localparam int NREQ = 2;
  localparam int IDW  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SIZE-1:0] req_a = '0;
  logic [NREQ*SIZE-1:0] req_b = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic [IDW-1:0]       resp_id;
  logic [SIZE-1:0]      resp_q;
  logic [SIZE-1:0]      resp_r;
  logic                 resp_dbz;

  always #5 clk = ~clk;

  divider_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_q     (resp_q),
    .resp_r     (resp_r),
    .resp_dbz   (resp_dbz)
  );

  // stimulus intent, applied each cycle at the falling edge
  logic            drv_rst_n = 1'b0;
  logic [NREQ-1:0] drv_valid = '0;
  logic [SIZE-1:0] drv_a [NREQ];
  logic [SIZE-1:0] drv_b [NREQ];
  logic            drv_rr = 1'b0;

  // transaction-level model: 0 = waiting for a request, 1 = computing,
  // 2 = holding a result
  int   m_mode = 0;
  int   m_ptr = 0;
  int   m_wait = 0;
  int   m_pend_id = 0, m_pend_q = 0, m_pend_r = 0;
  logic m_valid = 1'b0, m_dbz = 1'b0;
  int   m_id = 0, m_q = 0, m_r = 0;
  int   m_acc_id = -1;

  // DUT outputs sampled in the most recent cycle
  logic            obs_valid;
  logic [IDW-1:0]  obs_id;
  logic [SIZE-1:0] obs_q, obs_r;
  logic            obs_dbz;
  logic [NREQ-1:0] obs_ready;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (drv_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_wait = 0;
    m_valid = 1'b0; m_dbz = 1'b0; m_id = 0; m_q = 0; m_r = 0;
  endtask

  // One clock cycle: check registered outputs, apply inputs, check the
  // combinational grant, then advance the model across the rising edge.
  task automatic cycle();
    int              w;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    rst_n = drv_rst_n;
    if (!drv_rst_n) model_reset();
    #1;
    obs_valid = resp_valid; obs_id = resp_id; obs_q = resp_q;
    obs_r = resp_r; obs_dbz = resp_dbz;
    chk("resp_valid", resp_valid, m_valid);
    chk("resp_id", resp_id, m_id);
    chk("resp_q", resp_q, m_q);
    chk("resp_r", resp_r, m_r);
    chk("resp_dbz", resp_dbz, m_dbz);
    req_valid  = drv_valid;
    resp_ready = drv_rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*SIZE +: SIZE] = drv_a[i];
      req_b[i*SIZE +: SIZE] = drv_b[i];
    end
    #1;
    w = (m_mode == 0 && drv_rst_n) ? model_winner() : -1;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    obs_ready = req_ready;
    chk("req_ready", req_ready, exp_ready);
    chk("req_ready_onehot", ($countones(req_ready) <= 1), 1);
    @(posedge clk);
    cyc++;
    m_acc_id = -1;
    if (drv_rst_n) begin
      case (m_mode)
        0: if (w >= 0) begin
          m_acc_id = w;
          m_ptr = (w + 1) % NREQ;
          if (drv_b[w] == 0) begin
            m_mode = 2; m_valid = 1'b1; m_id = w;
            m_q = (1 << SIZE) - 1; m_r = int'(drv_a[w]); m_dbz = 1'b1;
          end else begin
            m_mode = 1; m_wait = SIZE; m_pend_id = w;
            m_pend_q = int'(drv_a[w]) / int'(drv_b[w]);
            m_pend_r = int'(drv_a[w]) % int'(drv_b[w]);
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) begin
            m_mode = 2; m_valid = 1'b1; m_id = m_pend_id;
            m_q = m_pend_q; m_r = m_pend_r; m_dbz = 1'b0;
          end
        end
        default: if (drv_rr) begin
          m_valid = 1'b0; m_mode = 0;
        end
      endcase
    end
  endtask

  // Single requester transaction with literal expectations. A normal divide
  // raises resp_valid SIZE edges after the accept edge; a zero divisor shows
  // it already in the cycle right after the accept.
  task automatic do_req(int id, int a, int b, int eq, int er, int edbz);
    int acc = -1;
    int seen = -1;
    drv_valid = '0; drv_valid[id] = 1'b1;
    drv_a[id] = SIZE'(a); drv_b[id] = SIZE'(b); drv_rr = 1'b1;
    for (int n = 0; n < 40 && acc < 0; n++) begin
      cycle();
      if (m_acc_id == id) acc = cyc;
    end
    drv_valid[id] = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
    for (int n = 0; n < 40 && seen < 0; n++) begin
      cycle();
      if (obs_valid) seen = cyc;
    end
    if (seen < 0) begin
      chk("resp_timeout", 0, 1);
    end else begin
      if (b == 0) chk("dbz_latency", seen - acc, 1);
      else        chk("div_latency", seen - acc - 1, SIZE);
      chk("lit_id", obs_id, id);
      chk("lit_q", obs_q, eq);
      chk("lit_r", obs_r, er);
      chk("lit_dbz", obs_dbz, edbz);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int prev_id, prev_cyc, got, done_seen;
    for (int i = 0; i < NREQ; i++) begin
      drv_a[i] = '0; drv_b[i] = '0;
    end

    // reset state
    drv_rst_n = 1'b0;
    repeat (3) cycle();
    chk("rst_resp_valid", obs_valid, 0);
    chk("rst_resp_q", obs_q, 0);
    chk("rst_req_ready", obs_ready, 0);
    drv_rst_n = 1'b1;
    cycle();

    // directed transactions
    do_req(0, 200, 7, 28, 4, 0);
    do_req(1, 255, 1, 255, 0, 0);
    do_req(1, 5, 9, 0, 5, 0);
    do_req(0, 17, 0, 255, 17, 1);
    do_req(0, 9, 3, 3, 0, 0);

    // both requesters persistent: grants alternate, SIZE+2 cycles apart;
    // last accept was requester 0, so requester 1 is next
    drv_a[0] = 8'd100; drv_b[0] = 8'd3;
    drv_a[1] = 8'd77;  drv_b[1] = 8'd5;
    drv_valid = '1; drv_rr = 1'b1;
    prev_id = 0; prev_cyc = -1;
    for (int n = 0; n < 60; n++) begin
      cycle();
      if (obs_ready != '0) begin
        chk("rr_grant", obs_ready, 1 << ((prev_id + 1) % NREQ));
        if (prev_cyc >= 0) chk("rr_spacing", cyc - prev_cyc, SIZE + 2);
        prev_cyc = cyc;
        got = 0;
        for (int i = 0; i < NREQ; i++) if (obs_ready[i]) got = i;
        prev_id = got;
      end
    end

    // consumer stall in DONE
    drv_rr = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 30 && !done_seen; n++) begin
      cycle();
      if (obs_valid) done_seen = 1;
    end
    if (!done_seen) chk("stall_wait_timeout", 0, 1);
    for (int n = 0; n < 20; n++) begin
      cycle();
      chk("stall_valid", obs_valid, 1);
      chk("stall_ready", obs_ready, 0);
    end
    drv_rr = 1'b1;
    cycle();
    cycle();
    chk("after_hs_valid", obs_valid, 0);
    chk("after_hs_grant", (obs_ready != '0), 1);

    // reset three cycles into the computation just accepted
    repeat (3) cycle();
    drv_rst_n = 1'b0;
    cycle();
    chk("midrst_valid", obs_valid, 0);
    chk("midrst_id", obs_id, 0);
    chk("midrst_q", obs_q, 0);
    chk("midrst_r", obs_r, 0);
    chk("midrst_ready", obs_ready, 0);
    cycle();
    drv_rst_n = 1'b1;
    cycle();
    chk("post_rst_grant", obs_ready, 2'b01);

    // randomized traffic; requests stay stable until accepted
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_acc_id == i || !drv_valid[i]) begin
          if (m_acc_id == i || $urandom_range(0, 2) == 0) begin
            drv_valid[i] = 1'($urandom_range(0, 1));
            drv_a[i] = SIZE'($urandom_range(0, 255));
            drv_b[i] = ($urandom_range(0, 7) == 0) ? '0 : SIZE'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          drv_valid[i] = 1'b0;
        end
      end
      drv_rr = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
